ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum WAIT cycles before a transfer is aborted (range 2..255).
REQ-002 hclk  input  1  bus clock; all state changes on the rising edge.
REQ-003 hreset  input  1  reset, asynchronous, active-high.
REQ-004 m0_req / m1_req  input  1  master N requests a single transfer; held high until mN_gnt.
REQ-005 m0_addr / m1_addr  input  32  master N transfer address.
REQ-006 m0_write / m1_write  input  1  master N direction (1 write, 0 read).
REQ-007 m0_wdata / m1_wdata  input  32  master N write data.
REQ-008 m0_gnt / m1_gnt  output  1  one-cycle pulse: command accepted and latched.
REQ-009 m0_done / m1_done  output  1  one-cycle pulse: transfer finished.
REQ-010 err  output  1  valid with any mN_done; 1 = transfer timed out.
REQ-011 rdata  output  32  read data; shared by both masters, valid with mN_done for reads.
REQ-012 hsel  output  1  slave select.
REQ-013 haddr  output  32  slave address.
REQ-014 hwrite  output  1  slave direction.
REQ-015 hready  output  1  address/control valid to slave.
REQ-016 hwdata  output  32  slave write data.
REQ-017 hreadyout  input  1  slave transfer-complete.
REQ-018 hrdata  input  32  slave read data, valid while hreadyout=1.

Function
REQ-019 States: IDLE, SEL, WAIT, DONE; all outputs are registered or decoded from registers only, with no combinational input-to-output path.
REQ-020 IDLE: if any mN_req=1, pick a winner, latch its addr/write/wdata into command registers, pulse its gnt in the next cycle, and go to SEL; otherwise stay in IDLE.
REQ-021 Arbitration is round-robin via a last_grant register: a lone requester wins; if both request, the master not in last_grant wins; last_grant updates to the winner.
REQ-022 Requests are sampled only in IDLE; a losing request stays pending and is served in a later IDLE cycle.
REQ-023 SEL (exactly 1 cycle): hsel=1, hready=1, haddr/hwrite/hwdata = command registers; next state is WAIT.
REQ-024 WAIT: hsel=0, hready=1, haddr/hwrite/hwdata held unchanged; timeout counter increments each cycle.
REQ-025 WAIT with hreadyout=1: if the command is a read, capture hrdata into rdata; err<=0; go to DONE.
REQ-026 WAIT with counter = TIMEOUT-1 and hreadyout=0: rdata<=0, err<=1, go to DONE.
REQ-027 If hreadyout=1 in the same cycle the count reaches TIMEOUT-1, hreadyout wins (REQ-025).
REQ-028 DONE (exactly 1 cycle): pulse done of the owning master, hready=0, hsel=0; next state is IDLE; counter clears.
REQ-029 A write transfer leaves rdata unchanged.
REQ-030 In all states other than SEL, hsel=0; hready=0 in IDLE and DONE.
REQ-031 Latency with an immediately completing slave: req seen in cycle t -> gnt in t+1 -> hreadyout in t+4 -> done in t+5 -> IDLE in t+6.
REQ-032 At most one gnt and at most one done are high in any cycle; each gnt is followed by exactly one done for the same master.

Reset
REQ-033 hreset=1 forces, asynchronously: state=IDLE; gnt, done, err, hsel, hready, hwrite = 0; haddr, hwdata, rdata = 0; counter = 0; last_grant = m1 (so m0 wins the first contention).
REQ-034 Reset asserted mid-transfer abandons the transfer, and no done is issued for it.

Verification
REQ-035 m0 write addr=0x3, wdata=0xDEADBEEF, with a single-cycle-response slave model -> m0_gnt at t+1, hsel high only at t+1, m0_done at t+5, err=0.
REQ-036 m1 read addr=0x3 after REQ-035 -> m1_done at t+5, rdata=0xDEADBEEF, err=0.
REQ-037 m0_req and m1_req both high from reset -> grant order m0, m1, m0, m1 over 4 transfers; no overlapping gnt/done.
REQ-038 Slave holds hreadyout=0 with TIMEOUT=16 -> done exactly 16 WAIT cycles after SEL, err=1, rdata=0, and the next transfer proceeds normally.
REQ-039 hreset pulsed during WAIT -> all outputs 0 in the same cycle, no done, and a new request afterwards is granted to m0.
REQ-040 hreadyout rises in the final timeout cycle -> err=0 and read data is captured.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Two-master arbiter that serialises single transfers onto one AHB-style slave port.
// Round-robin arbitration, one outstanding transfer, with a bounded slave wait.
module ahb_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        hclk,
  input  logic        hreset,

  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,

  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,

  output logic        err,
  output logic [31:0] rdata,

  output logic        hsel,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic        hready,
  output logic [31:0] hwdata,
  input  logic        hreadyout,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEL,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        winner;

  // Contention goes to the master that was not served last; a lone requester always wins.
  assign winner = (m0_req && m1_req) ? ~last_grant_q : m1_req;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through the case can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d      = winner;
          last_grant_d = winner;
          addr_d       = winner ? m1_addr  : m0_addr;
          write_d      = winner ? m1_write : m0_write;
          wdata_d      = winner ? m1_wdata : m0_wdata;
          state_d      = ST_SEL;
        end
      end
      ST_SEL: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A response in the last allowed cycle still counts as a normal completion.
        if (hreadyout) begin
          if (!write_q) rdata_d = hrdata;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_CNT) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= 32'h0;
      write_q      <= 1'b0;
      wdata_q      <= 32'h0;
      cnt_q        <= 8'd0;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Every output is a register or a decode of the state/owner registers.
  assign hsel    = (state_q == ST_SEL);
  assign hready  = (state_q == ST_SEL) || (state_q == ST_WAIT);
  assign m0_gnt  = (state_q == ST_SEL)  && !owner_q;
  assign m1_gnt  = (state_q == ST_SEL)  &&  owner_q;
  assign m0_done = (state_q == ST_DONE) && !owner_q;
  assign m1_done = (state_q == ST_DONE) &&  owner_q;
  assign haddr   = addr_q;
  assign hwrite  = write_q;
  assign hwdata  = wdata_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios plus randomized rounds, checked against a
// transaction-level model of grant order, completion latency, error and read data.
module tb_ahb_arbiter;

  localparam int unsigned T = 16;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m1_gnt, m1_done, err;
  logic [31:0] rdata;
  logic        hsel, hwrite, hready, hreadyout;
  logic [31:0] haddr, hwdata, hrdata;

  always #5 hclk = ~hclk;

  ahb_arbiter #(.TIMEOUT(T)) dut (
    .hclk(hclk), .hreset(hreset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done),
    .err(err), .rdata(rdata),
    .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hready(hready), .hwdata(hwdata),
    .hreadyout(hreadyout), .hrdata(hrdata)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  bit          mdl_last;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic [31:0] exp_mem [logic [31:0]];

  // Slave environment state
  logic [31:0] smem [logic [31:0]];
  int          slv_delay = 2;
  int          slv_cnt   = 0;
  bit          slv_on    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_get(input logic [31:0] addr);
    return exp_mem.exists(addr) ? exp_mem[addr] : 32'h0;
  endfunction

  // Slave: raises hreadyout slv_delay cycles after the select cycle and holds it until done.
  initial begin
    hreadyout = 1'b0;
    hrdata    = 32'h0;
    forever begin
      @(posedge hclk);
      #1;
      if (hreset) begin
        slv_on    = 1'b0;
        hreadyout = 1'b0;
      end else if (m0_done || m1_done) begin
        if (slv_on && hreadyout && hwrite) smem[haddr] = hwdata;
        slv_on    = 1'b0;
        hreadyout = 1'b0;
      end else if (hsel) begin
        slv_on    = 1'b1;
        slv_cnt   = 0;
        hreadyout = 1'b0;
      end else if (slv_on) begin
        slv_cnt++;
        hreadyout = (slv_cnt >= slv_delay);
      end
      if (hreadyout) hrdata = smem.exists(haddr) ? smem[haddr] : 32'h0;
      else           hrdata = $urandom;
    end
  end

  task automatic run_round(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int dl0, input int dl1);
    int          order[$];
    bit          wr[2];
    logic [31:0] ad[2];
    logic [31:0] wd[2];
    int          dl[2];
    wr[0] = w0; wr[1] = w1; ad[0] = a0; ad[1] = a1;
    wd[0] = d0; wd[1] = d1; dl[0] = dl0; dl[1] = dl1;

    if (r0 && r1) begin
      if (mdl_last) begin order.push_back(0); order.push_back(1); end
      else          begin order.push_back(1); order.push_back(0); end
    end else if (r0) order.push_back(0);
    else             order.push_back(1);

    @(posedge hclk);
    #1;
    m0_req = r0; m0_addr = a0; m0_write = w0; m0_wdata = d0;
    m1_req = r1; m1_addr = a1; m1_write = w1; m1_wdata = d1;

    foreach (order[k]) begin
      int w        = order[k];
      int n        = 0;
      bit seen     = 1'b0;
      int hr_cnt   = 0;
      int hs_cnt   = 0;
      int g_cnt    = 0;
      int exp_wait = (dl[w] > int'(T)) ? int'(T) : dl[w];
      bit tmo      = (dl[w] > int'(T));

      while (!seen && n < 40) begin
        @(negedge hclk);
        n++;
        seen = m0_gnt || m1_gnt;
      end
      check("gnt_latency", 64'(n), 64'(2));
      check("gnt_master", 64'({m1_gnt, m0_gnt}), (w == 1) ? 64'h2 : 64'h1);
      check("sel_cmd", 64'({hsel, hready, hwrite, haddr}), 64'({1'b1, 1'b1, wr[w], ad[w]}));
      check("sel_wdata", 64'(hwdata), 64'(wd[w]));
      slv_delay = dl[w];
      mdl_last  = (w == 1);

      @(posedge hclk);
      #1;
      if (w == 1) m1_req = 1'b0;
      else        m0_req = 1'b0;

      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        @(negedge hclk);
        n++;
        seen = m0_done || m1_done;
        if (!seen) begin
          hr_cnt += int'(hready);
          hs_cnt += int'(hsel);
          g_cnt  += int'(m0_gnt || m1_gnt);
        end
      end

      if (tmo) begin
        exp_err   = 1'b1;
        exp_rdata = 32'h0;
      end else begin
        exp_err = 1'b0;
        if (wr[w]) exp_mem[ad[w]] = wd[w];
        else       exp_rdata = mem_get(ad[w]);
      end

      check("done_latency", 64'(n), 64'(exp_wait + 1));
      check("done_master", 64'({m1_done, m0_done}), (w == 1) ? 64'h2 : 64'h1);
      check("wait_bus", 64'({hs_cnt[7:0], hr_cnt[7:0], g_cnt[7:0]}),
            64'({8'd0, 8'(exp_wait), 8'd0}));
      check("done_bus", 64'({hsel, hready, m0_gnt, m1_gnt}), 64'h0);
      check("err", 64'(err), 64'(exp_err));
      check("rdata", 64'(rdata), 64'(exp_rdata));
    end
  endtask

  task automatic reset_mid_wait();
    int n    = 0;
    bit seen = 1'b0;
    int dn   = 0;
    @(posedge hclk);
    #1;
    m0_req = 1'b1; m0_addr = 32'h5; m0_write = 1'b1; m0_wdata = 32'hBAD0BAD0;
    slv_delay = 30;
    while (!seen && n < 40) begin
      @(negedge hclk);
      n++;
      seen = m0_gnt;
    end
    check("rst_gnt_seen", 64'(seen), 64'h1);
    @(posedge hclk);
    #1;
    m0_req = 1'b0;
    repeat (3) @(negedge hclk);
    check("rst_in_wait", 64'({hsel, hready}), 64'h1);
    #2;
    hreset = 1'b1;
    #1;
    check("rst_async_ctl", 64'({m0_gnt, m1_gnt, m0_done, m1_done, err, hsel, hready, hwrite}), 64'h0);
    check("rst_async_bus", 64'({haddr, hwdata}), 64'h0);
    check("rst_async_rdata", 64'(rdata), 64'h0);
    repeat (3) begin
      @(negedge hclk);
      dn += int'(m0_done || m1_done);
    end
    hreset    = 1'b0;
    mdl_last  = 1'b1;
    exp_err   = 1'b0;
    exp_rdata = 32'h0;
    repeat (4) begin
      @(negedge hclk);
      dn += int'(m0_done || m1_done || m0_gnt || m1_gnt);
    end
    check("rst_no_done", 64'(dn), 64'h0);
  endtask

  initial begin
    m0_req = 1'b0; m0_addr = 32'h0; m0_write = 1'b0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_addr = 32'h0; m1_write = 1'b0; m1_wdata = 32'h0;
    hreset = 1'b1;
    repeat (3) @(negedge hclk);
    check("reset_ctl", 64'({m0_gnt, m1_gnt, m0_done, m1_done, err, hsel, hready, hwrite}), 64'h0);
    check("reset_bus", 64'({haddr, hwdata}), 64'h0);
    check("reset_rdata", 64'(rdata), 64'h0);
    hreset    = 1'b0;
    mdl_last  = 1'b1;
    exp_err   = 1'b0;
    exp_rdata = 32'h0;

    // Contention straight out of reset: m0, m1, m0, m1
    run_round(1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 32'h2, 32'h11111111, 32'h22222222, 3, 4);
    run_round(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h2, 32'h33333333, 32'h44444444, 2, 3);

    // Write then read back through the other master
    run_round(1'b1, 1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 32'hDEADBEEF, 32'h0, 3, 3);
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3, 32'h0, 32'h0, 3, 3);

    // Timeout on a read, then a normal transfer
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h3, 32'h0, 32'h0, 32'h0, 25, 3);
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3, 32'h0, 32'h0, 3, 2);

    // Response in the final allowed cycle
    run_round(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h7, 32'h0, 32'h12345678, 3, 5);
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0, 32'h0, 16, 3);

    // Reset during WAIT, then contention must favour m0
    reset_mid_wait();
    run_round(1'b1, 1'b1, 1'b0, 1'b0, 32'h7, 32'h3, 32'h0, 32'h0, 2, 2);

    for (int r = 0; r < 60; r++) begin
      int pick = $urandom_range(1, 3);
      run_round(pick[0], pick[1],
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 7)), 32'($urandom_range(0, 7)),
                $urandom, $urandom,
                $urandom_range(2, 20), $urandom_range(2, 20));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
